// File: rtl/register_bank_nested.sv
// Nested-interrupt register file: NUM_BANKS full register sets, push copies the
// active bank into the next one register per cycle, pop returns in one cycle.
module register_bank_nested #(
  parameter int REG_NUM    = 32,
  parameter int DATA_WIDTH = 64,
  parameter int NUM_BANKS  = 4,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(REG_NUM)-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         write_en,
  input  logic [$clog2(REG_NUM)-1:0]   read_addr_a,
  input  logic [$clog2(REG_NUM)-1:0]   read_addr_b,
  output logic [DATA_WIDTH-1:0]        data_out_a,
  output logic [DATA_WIDTH-1:0]        data_out_b,
  input  logic                         irq_enter,
  input  logic                         irq_exit,
  input  logic                         err_clr,
  output logic                         busy,
  output logic [$clog2(NUM_BANKS)-1:0] depth,
  output logic                         err_overflow,
  output logic                         err_underflow,
  output logic                         err_busy
);

  localparam int AW = $clog2(REG_NUM);
  localparam int BW = $clog2(NUM_BANKS);
  localparam logic [BW-1:0] TOP_BANK = BW'(NUM_BANKS - 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);

  typedef enum logic {IDLE, COPY} state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           depth_q, depth_d;
  logic [BW-1:0]           dst_bank;
  logic [AW-1:0]           idx_q, idx_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, bsy_q, bsy_d;
  logic                    ovf_set, unf_set, bsy_set;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_BANKS][REG_NUM];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_BANKS][REG_NUM];

  // During a copy depth_q still names the source bank; it only advances at the end.
  assign dst_bank = depth_q + BW'(1);

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    bsy_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write_en && !((ZERO_REG != 0) && (write_addr == '0))) begin
          regs_d[depth_q][write_addr] = data_in;
        end
        if (irq_enter) begin
          if (depth_q != TOP_BANK) begin
            state_d = COPY;
            idx_d   = '0;
          end else begin
            ovf_set = 1'b1;
          end
        end else if (irq_exit) begin
          if (depth_q != '0) begin
            depth_d = depth_q - BW'(1);
          end else begin
            unf_set = 1'b1;
          end
        end
      end
      COPY: begin
        regs_d[dst_bank][idx_q] = regs_q[depth_q][idx_q];
        idx_d = idx_q + AW'(1);
        if (idx_q == LAST_IDX) begin
          depth_d = dst_bank;
          state_d = IDLE;
        end
        if (irq_enter || irq_exit) begin
          bsy_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh error in the same cycle as err_clr survives the clear.
    ovf_d = (ovf_q & ~err_clr) | ovf_set;
    unf_d = (unf_q & ~err_clr) | unf_set;
    bsy_d = (bsy_q & ~err_clr) | bsy_set;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      depth_q <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      bsy_q   <= 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 0; r < REG_NUM; r++) begin
          regs_q[b][r] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      bsy_q   <= bsy_d;
      regs_q  <= regs_d;
    end
  end

  assign data_out_a    = ((ZERO_REG != 0) && (read_addr_a == '0)) ? '0 : regs_q[depth_q][read_addr_a];
  assign data_out_b    = ((ZERO_REG != 0) && (read_addr_b == '0)) ? '0 : regs_q[depth_q][read_addr_b];
  assign busy          = (state_q == COPY);
  assign depth         = depth_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;
  assign err_busy      = bsy_q;

endmodule

// File: tb/tb_register_bank_nested.sv
// Scoreboard bench for register_bank_nested: a context-stack reference model
// predicts every cycle's outputs; a negedge monitor pops and compares them.
module tb_register_bank_nested;

  localparam int RN = 32;
  localparam int DW = 64;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [4:0]    write_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic          write_en = 1'b0;
  logic [4:0]    read_addr_a = '0;
  logic [4:0]    read_addr_b = '0;
  logic [DW-1:0] data_out_a, data_out_b;
  logic          irq_enter = 1'b0;
  logic          irq_exit = 1'b0;
  logic          err_clr = 1'b0;
  logic          busy;
  logic [1:0]    depth;
  logic          err_overflow, err_underflow, err_busy;

  register_bank_nested #(.REG_NUM(RN), .DATA_WIDTH(DW), .NUM_BANKS(NB), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .write_addr(write_addr), .data_in(data_in),
    .write_en(write_en), .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .data_out_a(data_out_a), .data_out_b(data_out_b), .irq_enter(irq_enter),
    .irq_exit(irq_exit), .err_clr(err_clr), .busy(busy), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .err_busy(err_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int          dep;
    bit          bsy, ov, un, bz;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model: a stack of whole register sets; a push copies instantly
  // and just hides the new level for RN cycles.
  logic [DW-1:0] mem [NB][RN];
  int m_depth, m_busy;
  bit m_ov, m_un, m_bz;

  task automatic cmp(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, got, want);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [4:0] a);
    return (a == 0) ? '0 : mem[m_depth][a];
  endfunction

  task automatic m_reset();
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < RN; r++) mem[b][r] = '0;
    m_depth = 0; m_busy = 0; m_ov = 0; m_un = 0; m_bz = 0;
  endtask

  task automatic m_step();
    bit ov = 0, un = 0, bz = 0;
    if (m_busy > 0) begin
      if (irq_enter || irq_exit) bz = 1;
      m_busy--;
      if (m_busy == 0) m_depth++;
    end else begin
      if (write_en && write_addr != 0) mem[m_depth][write_addr] = data_in;
      if (irq_enter) begin
        if (m_depth < NB - 1) begin
          for (int r = 0; r < RN; r++) mem[m_depth + 1][r] = mem[m_depth][r];
          m_busy = RN;
        end else ov = 1;
      end else if (irq_exit) begin
        if (m_depth > 0) m_depth--;
        else un = 1;
      end
    end
    if (err_clr) begin m_ov = 0; m_un = 0; m_bz = 0; end
    m_ov |= ov; m_un |= un; m_bz |= bz;
  endtask

  // One clock: queue this cycle's expected outputs, then advance the model at the edge.
  task automatic cyc();
    exp_t e;
    if (!reset) m_reset();
    e.cyc = cyc_n; e.a = m_read(read_addr_a); e.b = m_read(read_addr_b);
    e.dep = m_depth; e.bsy = (m_busy > 0); e.ov = m_ov; e.un = m_un; e.bz = m_bz;
    sbq.push_back(e);
    @(posedge clk);
    if (!reset) m_reset(); else m_step();
    cyc_n++;
    #1;
    write_en = 0; irq_enter = 0; irq_exit = 0; err_clr = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      cmp("sb_rd_a", data_out_a, e.a);
      cmp("sb_rd_b", data_out_b, e.b);
      cmp("sb_depth", DW'(depth), DW'(e.dep));
      cmp("sb_busy", DW'(busy), DW'(e.bsy));
      cmp("sb_flags", DW'({err_overflow, err_underflow, err_busy}), DW'({e.ov, e.un, e.bz}));
    end
  end

  task automatic wr(input logic [4:0] a, input logic [DW-1:0] d);
    write_en = 1; write_addr = a; data_in = d; cyc();
  endtask

  task automatic peek(input string nm, input logic [4:0] a, input logic [DW-1:0] want);
    read_addr_a = a; #1; cmp(nm, data_out_a, want);
  endtask

  task automatic wait_copy();
    for (int i = 0; i < RN; i++) cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc_n);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bcount;
    m_reset();
    @(posedge clk); #1;
    cyc(); cyc();
    cmp("reset_depth", DW'(depth), '0);
    cmp("reset_busy", DW'(busy), '0);
    reset = 1;
    cyc();

    // Basic write and zero register
    wr(5, 'hA5); wr(0, 'hFF);
    peek("x5_bank0", 5, 'hA5);
    peek("x0_zero", 0, '0);
    cmp("depth0", DW'(depth), '0);

    // Single push/pop, busy length
    wr(5, 'h11);
    irq_enter = 1; cyc();
    bcount = 0;
    for (int i = 0; i < RN + 4; i++) begin
      if (busy) bcount++;
      cyc();
    end
    cmp("busy_len", DW'(bcount), DW'(RN));
    cmp("depth_after_push", DW'(depth), 1);
    peek("x5_copied", 5, 'h11);
    wr(5, 'h22);
    irq_exit = 1; cyc();
    cmp("depth_after_pop", DW'(depth), '0);
    peek("x5_restored", 5, 'h11);

    // Nest to the top level
    for (int l = 0; l < NB - 1; l++) begin
      wr(7, DW'(100 + l));
      irq_enter = 1; cyc();
      wait_copy();
    end
    wr(7, 103);
    irq_enter = 1; cyc();
    cmp("overflow_flag", DW'(err_overflow), 1);
    cmp("overflow_depth", DW'(depth), 3);
    for (int l = NB - 1; l > 0; l--) begin
      peek("x7_level", 7, DW'(100 + l));
      irq_exit = 1; cyc();
    end
    peek("x7_level0", 7, 100);
    irq_exit = 1; cyc();
    cmp("underflow_flag", DW'(err_underflow), 1);
    err_clr = 1; cyc();

    // Simultaneous enter and exit at depth 0
    irq_enter = 1; irq_exit = 1; cyc();
    wait_copy();
    cmp("simul_depth", DW'(depth), 1);
    cmp("simul_no_underflow", DW'(err_underflow), '0);
    irq_exit = 1; cyc();

    // Requests and writes during a copy
    irq_enter = 1; cyc();
    cyc(); cyc();
    irq_exit = 1; write_en = 1; write_addr = 3; data_in = 'h99; cyc();
    for (int i = 0; i < RN - 3; i++) cyc();
    cmp("busy_err_flag", DW'(err_busy), 1);
    cmp("busy_err_depth", DW'(depth), 1);
    peek("x3_unchanged", 3, '0);
    err_clr = 1; cyc();
    cmp("flags_cleared", DW'({err_overflow, err_underflow, err_busy}), '0);
    irq_exit = 1; cyc();

    // Reset in the middle of a copy
    wr(9, 'h5A5A);
    irq_enter = 1; cyc();
    for (int i = 0; i < 10; i++) cyc();
    reset = 0; #1;
    cmp("midcopy_busy", DW'(busy), '0);
    cmp("midcopy_depth", DW'(depth), '0);
    cyc();
    reset = 1;
    for (int i = 0; i < RN / 2; i++) begin
      read_addr_a = 5'(i); read_addr_b = 5'(i + RN / 2); cyc();
    end
    peek("x9_cleared", 9, '0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      write_en    = ($urandom_range(1, 0) == 1);
      write_addr  = 5'($urandom_range(RN - 1, 0));
      data_in     = {$urandom, $urandom};
      read_addr_a = 5'($urandom_range(RN - 1, 0));
      read_addr_b = 5'($urandom_range(RN - 1, 0));
      irq_enter   = ($urandom_range(29, 0) == 0);
      irq_exit    = ($urandom_range(24, 0) == 0);
      err_clr     = ($urandom_range(39, 0) == 0);
      cyc();
    end

    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_bank_nested.md
# register_bank_nested

Multi-level shadowed CPU register file for nested interrupts. It holds NUM_BANKS complete register sets: bank 0 is the main context and banks 1..NUM_BANKS-1 are interrupt contexts. Interrupt entry pushes a new context by copying the active bank into the next bank, one register per cycle. Interrupt exit pops back to the previous bank in one cycle. It is the drop-in successor to the two-set main/shadow CPU bank and sits between decode (reads) and writeback (writes).

## Interface
- REG_NUM, 32: registers per bank; power of 2, ≥ 2.
- DATA_WIDTH, 64: register width.
- NUM_BANKS, 4: context levels including main; ≥ 2.
- ZERO_REG, 1: when 1, address 0 reads as 0 and writes to it are dropped.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- write_addr  in  $clog2(REG_NUM)  write address.
- data_in  in  DATA_WIDTH  write data.
- write_en  in  1  write strobe; acts on the active bank.
- read_addr_a / read_addr_b  in  $clog2(REG_NUM)  read addresses.
- data_out_a / data_out_b  out  DATA_WIDTH  combinational read data from the active bank.
- irq_enter  in  1  single-cycle pulse requesting a context push.
- irq_exit  in  1  single-cycle pulse requesting a context pop.
- err_clr  in  1  clears all sticky error flags.
- busy  out  1  copy in progress; the pipeline must stall.
- depth  out  $clog2(NUM_BANKS)  index of the active bank.
- err_overflow / err_underflow / err_busy  out  1  sticky error flags.

## Operation
- Reset: all banks are cleared to 0, depth=0, busy=0, FSM is IDLE, all error flags are 0.
- Reads: data_out_x = bank[depth][read_addr_x].
  - With ZERO_REG=1, reading address 0 returns 0.
  - No write-through: a read in the same cycle as a write to the same address returns the old value.
- Writes, IDLE state: on a rising edge with write_en=1, bank[depth][write_addr] <= data_in.
- Writes, COPY state: write_en is ignored (no effect, no error). The stall contract makes this case illegal.
- IDLE, irq_enter=1, depth<NUM_BANKS-1:
  - go to COPY, set busy=1, src=depth, dst=depth+1, idx=0.
- IDLE, irq_enter=1, depth=NUM_BANKS-1: set err_overflow; no state change.
- IDLE, irq_exit=1, depth>0: depth <= depth-1. The popped bank's contents are left unchanged (stale).
- IDLE, irq_exit=1, depth=0: set err_underflow; no state change.
- IDLE, irq_enter and irq_exit in the same cycle: the enter is processed, the exit is discarded, and no error is flagged for the exit.
- COPY:
  - each cycle, bank[dst][idx] <= bank[src][idx] and idx increments.
  - when idx=REG_NUM-1, that copy completes, depth <= dst, busy <= 0, and the FSM returns to IDLE.
  - all addresses are copied, including address 0.
- COPY, irq_enter or irq_exit asserted: the request is ignored and err_busy is set.
- err_clr=1 clears all three flags. If a new error occurs in the same cycle, the new error wins.
- Reset asserted mid-COPY: everything returns immediately to reset values. No partial state persists.

## Timing
- Read latency: 0 cycles (combinational from the address and depth registers).
- Write latency: 1 edge.
- irq_enter sampled at edge E:
  - busy=1 from E through E+REG_NUM.
  - copies occur at edges E+1 through E+REG_NUM.
  - depth and busy update at edge E+REG_NUM.
  - the new bank is readable and writable in the cycle after E+REG_NUM.
- Reads during COPY return the source bank, which is unchanged while the copy runs.
- irq_exit sampled at edge E: depth changes at E; reads in the next cycle come from bank depth-1.
- Error flags are set at the edge that samples the offending request.

## Test plan
- Reset, then write x5=0xA5 and x0=0xFF in bank 0. Expect: read x5=0xA5, x0=0, depth=0.
- Write x5=0x11 in bank 0, then pulse irq_enter. Expect: busy high for exactly REG_NUM=32 cycles; then depth=1 and x5=0x11. Write x5=0x22, pulse irq_exit. Expect: depth=0, x5=0x11.
- Nest to depth 3 with NUM_BANKS=4, writing a distinct value to x7 at each level. Then:
  - one more irq_enter → err_overflow=1, depth stays 3.
  - pop three times; expect x7 to read back each level's value.
  - a fourth irq_exit → err_underflow=1.
- Pulse irq_enter and irq_exit together at depth 0. Expect: the copy starts, depth=1 after completion, err_underflow=0.
- During COPY: pulse irq_exit and drive write_en to x3=0x99. Expect: err_busy=1, x3 unchanged after the copy, depth=1. Then err_clr=1 → all flags 0.
- Assert reset at copy idx=10. Expect: busy=0, depth=0, all registers 0 on the cycle after release.
